// File: rtl/conv1_maxpool_relu_pkg.sv
// Shared conv1 / pooling geometry constants, also used by conv2_buf to size its window.
// Latency: n/a (constants only).
// Backpressure: n/a.
package conv1_maxpool_relu_pkg;

  // Sample width shared by conv1 output, this pooling stage and conv2_buf input.
  localparam int CONV1_DATA_BITS = 12;

  // conv1 feature-map geometry (input side of the pooling stage).
  localparam int CONV1_OUT_W = 24;
  localparam int CONV1_OUT_H = 24;

  // Pooled map geometry (input side of conv2_buf).
  localparam int POOL_OUT_W = CONV1_OUT_W / 2;
  localparam int POOL_OUT_H = CONV1_OUT_H / 2;

endpackage : conv1_maxpool_relu_pkg

// File: rtl/conv1_maxpool_relu_pool_line_buf.sv
// Pool line buffer: holds one horizontal pair-max per pooling column across the even->odd row gap.
// Latency: write takes effect on the next clk edge; read is combinational.
// Backpressure: none; single write port and single read port, always ready.
//
// Ports:
//   clk      rising-edge clock
//   wr_en    write strobe for wr_addr/wr_data
//   wr_addr  entry to write (pooling column index)
//   wr_data  value to store
//   rd_addr  entry to read (pooling column index)
//   rd_data  combinational read of rd_addr
module conv1_maxpool_relu_pool_line_buf #(
  parameter int DEPTH     = 12,
  parameter int DATA_BITS = 12,
  parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [AW-1:0]        rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  // Contents are always written on an even row before being read on the
  // following odd row, so no reset is needed.
  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule : conv1_maxpool_relu_pool_line_buf

// File: rtl/conv1_maxpool_relu.sv
// Streaming 2x2 / stride-2 signed max-pool followed by ReLU for one conv1 channel.
// Latency: 1 clk from the edge accepting a window's 4th pixel to valid_out.
// Backpressure: none; downstream must accept every data_out pulse, valid_in gaps freeze all state.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   valid_in    data_in carries one raster-order pixel this cycle
//   data_in     signed conv1 pixel
//   data_out    pooled + ReLU pixel (never negative), holds between pulses
//   valid_out   single-cycle pulse per pooled pixel
//   frame_done  pulses with the last pooled pixel of a frame
module conv1_maxpool_relu
  import conv1_maxpool_relu_pkg::*;
#(
  parameter int WIDTH     = CONV1_OUT_W,
  parameter int HEIGHT    = CONV1_OUT_H,
  parameter int DATA_BITS = CONV1_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_done
);

  localparam int CW    = (WIDTH > 1)  ? $clog2(WIDTH)  : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DEPTH = WIDTH / 2;
  localparam int AW    = (DEPTH > 1)  ? $clog2(DEPTH)  : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef logic signed [DATA_BITS-1:0] sample_t;

  function automatic sample_t smax(input sample_t a, input sample_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  sample_t       hold;
  sample_t       pix;
  sample_t       pair_max;
  sample_t       lb_rd;
  sample_t       win_max;
  logic          col_last;
  logic          row_last;
  logic          lb_wr;
  logic [AW-1:0] lb_addr;

  assign pix      = $signed(data_in);
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);

  // Even columns park their pixel in hold; the odd column that follows
  // completes the horizontal pair.
  assign pair_max = smax(hold, pix);
  assign win_max  = smax(pair_max, lb_rd);

  // Even rows store the pair max for the matching odd row to combine.
  assign lb_wr   = valid_in & ~row[0] & col[0];
  assign lb_addr = AW'(col >> 1);

  conv1_maxpool_relu_pool_line_buf #(
    .DEPTH     (DEPTH),
    .DATA_BITS (DATA_BITS),
    .AW        (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (lb_wr),
    .wr_addr (lb_addr),
    .wr_data (pair_max),
    .rd_addr (lb_addr),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      hold       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end

        if (!col[0]) begin
          hold <= pix;
        end

        // Odd row, odd column closes a 2x2 window: emit max with ReLU.
        if (row[0] && col[0]) begin
          data_out   <= win_max[DATA_BITS-1] ? '0 : win_max;
          valid_out  <= 1'b1;
          frame_done <= row_last & col_last;
        end
      end
    end
  end

endmodule : conv1_maxpool_relu

// File: tb/tb_conv1_maxpool_relu.sv
// Scoreboard bench for conv1_maxpool_relu: driver pushes expected pooled pixels, monitor pops on valid_out.
// Latency: expects valid_out in the cycle after the accepting edge of each window's 4th pixel.
// Backpressure: none; the monitor accepts every output.
module tb_conv1_maxpool_relu;

  localparam int W    = 24;
  localparam int H    = 24;
  localparam int DB   = 12;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_in;
  logic [DB-1:0] data_in;
  logic [DB-1:0] data_out;
  logic          valid_out;
  logic          frame_done;

  always #5 clk = ~clk;

  conv1_maxpool_relu #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .DATA_BITS (DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .frame_done (frame_done)
  );

  typedef struct {
    int data;
    bit fd;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   cyc    = 0;
  int   fd_cnt = 0;
  int   img  [NPIX];
  int   pool [NOUT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per output pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got data %0d with no pending expectation (t=%0t)", data_out, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("data_out", int'(data_out), e.data & 'hFFF);
          check("frame_done", int'(frame_done), int'(e.fd));
          check("latency_cycle", cyc, e.cyc);
        end
        if (frame_done) fd_cnt++;
      end else if (frame_done) begin
        check("frame_done_without_valid", int'(frame_done), 0);
      end
    end
  end

  task automatic set_ramp(input int base);
    for (int p = 0; p < NPIX; p++) img[p] = p + base;
    for (int r = 0; r < H / 2; r++)
      for (int c = 0; c < W / 2; c++)
        pool[r * (W / 2) + c] = (2 * r + 1) * W + 2 * c + 1 + base;
  endtask

  task automatic set_const(input int v, input int pv);
    for (int p = 0; p < NPIX; p++) img[p] = v;
    for (int i = 0; i < NOUT; i++) pool[i] = pv;
  endtask

  task automatic send_frame(input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      exp_t e;
      int   r;
      int   c;
      r = p / W;
      c = p % W;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          valid_in = 1'b0;
          data_in  = DB'($urandom);
          @(negedge clk);
        end
      end
      valid_in = 1'b1;
      data_in  = DB'(img[p]);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        e.data = pool[(r / 2) * (W / 2) + c / 2];
        e.fd   = (p == NPIX - 1);
        e.cyc  = cyc + 1;
        q.push_back(e);
      end
      @(negedge clk);
    end
  endtask

  task automatic drain();
    valid_in = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    check("drain_pending", q.size(), 0);
  endtask

  initial begin
    int fd0;
    // Reset with valid_in asserted: must be ignored.
    rst_n    = 1'b0;
    valid_in = 1'b1;
    data_in  = 12'h123;
    repeat (3) @(negedge clk);
    check("reset_data_out", int'(data_out), 0);
    check("reset_valid_out", int'(valid_out), 0);
    check("reset_frame_done", int'(frame_done), 0);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);

    // 1: ramp frame, outputs 25..575.
    set_ramp(0);
    send_frame(NPIX, 1'b0);
    drain();

    // 2: all -5 -> all zero after ReLU.
    set_const(-5, 0);
    send_frame(NPIX, 1'b0);
    drain();

    // 3: mixed-sign windows in the first pooled row, rest zero.
    set_const(0, 0);
    img[0]  = -3;   img[1]  = 7;   img[W+0]  = 100;  img[W+1]  = -100; pool[0] = 100;
    img[2]  = -3;   img[3]  = -7;  img[W+2]  = -1;   img[W+3]  = -2;   pool[1] = 0;
    img[4]  = -50;  img[5]  = -60; img[W+4]  = -70;  img[W+5]  = 40;   pool[2] = 40;
    img[6]  = 90;   img[7]  = -1;  img[W+6]  = 5;    img[W+7]  = 6;    pool[3] = 90;
    img[8]  = 1;    img[9]  = 80;  img[W+8]  = 2;    img[W+9]  = 3;    pool[4] = 80;
    img[10] = -2048; img[11] = 2047; img[W+10] = -1; img[W+11] = 0;    pool[5] = 2047;
    send_frame(NPIX, 1'b0);
    drain();

    // 4: ramp frame with random valid_in gaps.
    set_ramp(0);
    send_frame(NPIX, 1'b1);
    drain();

    // 5: back-to-back ramp then ramp+1000.
    fd0 = fd_cnt;
    set_ramp(0);
    send_frame(NPIX, 1'b0);
    set_ramp(1000);
    send_frame(NPIX, 1'b0);
    drain();
    check("frame_done_pulses", fd_cnt - fd0, 2);

    // 6: asynchronous reset mid-frame, away from any clock edge.
    set_ramp(0);
    send_frame(301, 1'b0);
    valid_in = 1'b1;
    data_in  = DB'(img[301]);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_data_out", int'(data_out), 0);
    check("async_rst_valid_out", int'(valid_out), 0);
    check("async_rst_frame_done", int'(frame_done), 0);
    check("async_rst_pending", q.size(), 0);
    q.delete();
    data_in = 12'd999;
    repeat (3) @(negedge clk);
    check("in_rst_valid_out", int'(valid_out), 0);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    @(negedge clk);
    set_ramp(0);
    send_frame(NPIX, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_conv1_maxpool_relu
